conv_frame_sink: RTL and testbench
==================================

Name: conv_frame_sink

Overview:
- Receiving end of the convolution pixel stream. Captures the `pxl_out`/`valid_out` raster stream of a conv stage (e.g. `conv_11`) into an on-chip frame buffer of D*D words.
- Tracks row/column position and flags frame completion.
- Replays the stored frame on a read-side handshake, so the next stage or a checker can consume it at its own pace.
- Sits between a conv stage and the next layer or result dump logic.

Parameters:
- D, 299, frame width = height in pixels; T = D*D words stored.
- data_width, 32, pixel word width (IEEE-754 single).
- addr_width, 17, buffer address width; must satisfy 2^addr_width >= D*D.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- start  input  1  one-cycle pulse: arm capture of a new frame.
- valid_in  input  1  pixel strobe from the conv stage.
- pxl_in  input  data_width  pixel word from the conv stage.
- rd_en  input  1  read request: fetch the next stored pixel.
- pxl_out  output  data_width  replayed pixel.
- valid_out  output  1  pxl_out valid, one-cycle pulse per read.
- busy  output  1  high in CAPTURE.
- frame_done  output  1  high in DONE and READOUT (frame available).
- overrun  output  1  sticky: a pixel arrived in DONE/READOUT.
- row  output  addr_width  row index of the next pixel to capture.
- col  output  addr_width  column index of the next pixel to capture.

Behaviour:
- Reset values:
  - pxl_out=0, valid_out=0, busy=0, frame_done=0, overrun=0, row=0, col=0.
  - State=IDLE; write/read counters=0.
  - Buffer contents are not cleared.
- Reset mid-operation: immediate return to IDLE with all counters cleared. Any partial frame is discarded logically.
- States: IDLE, CAPTURE, DONE, READOUT.
- IDLE:
  - valid_in is ignored and does not set overrun.
  - start moves to CAPTURE and clears wr_cnt, row, col and overrun.
  - If start and valid_in occur in the same cycle, that pixel is NOT captured.
- CAPTURE:
  - Each valid_in writes pxl_in to buf[wr_cnt] and increments wr_cnt.
  - col increments; when col==D-1 it wraps to 0 and row increments.
  - The write of pixel T-1 moves to DONE on the same edge; row/col return to 0.
  - Gaps in valid_in are allowed; counters hold while valid_in=0.
  - start in CAPTURE is ignored.
- DONE:
  - frame_done=1.
  - rd_en moves to READOUT and issues read of address 0. rd_cnt advances to 1 only if T>1; if T=1 the single read is also the last, and the state goes straight to IDLE.
  - valid_in sets overrun; the buffer is not written.
  - start in DONE is ignored; the frame must be drained first.
- READOUT:
  - Each rd_en reads buf[rd_cnt] and increments rd_cnt.
  - Read latency is 1 cycle: pxl_out updates and valid_out=1 on the edge after the rd_en edge.
  - valid_out=0 in any cycle without a read issued on the previous edge; pxl_out holds its last value.
  - The read of address T-1 moves to IDLE on the same edge (frame_done drops). Its data still appears one cycle later with valid_out=1.
  - rd_en in IDLE or CAPTURE is ignored (no valid_out).
  - valid_in in READOUT sets overrun.
- Arithmetic:
  - wr_cnt, rd_cnt, row and col are unsigned addr_width counters compared against T-1 and D-1.
  - No wrap past T. Pixel data is passed untouched and never interpreted.
- Buffer: single inferred RAM, one write port (CAPTURE) and one synchronous read port (DONE/READOUT). The ports are never used simultaneously.

Test Plan:
- D=4:
  - start, then 16 consecutive valid_in with pxl_in = 32'h3f800000 + k → busy falls and frame_done=1 on the edge of the 16th write. row/col sequence is (0,0),(0,1)…(0,3),(1,0)…(3,3), then (0,0).
  - After capture, 16 back-to-back rd_en → valid_out high for 16 cycles, starting 1 cycle after the first rd_en, with pxl_out = 32'h3f800000 + k in order. frame_done=0 after the 16th rd_en edge.
- Capture with valid_in gaps: 16 pixels over 40 cycles, random idle cycles → identical stored data. row/col hold during gaps.
- start and valid_in asserted in the same cycle in IDLE → that pixel is not stored, and wr_cnt=0 in the next cycle.
- valid_in in DONE → overrun=1 and stays 1. A subsequent readout returns the original frame unchanged. The next start clears overrun.
- Reset pulse after 7 captured pixels → all outputs 0, state IDLE. start plus 16 pixels then captures a full fresh frame correctly.
- rd_en in IDLE, and rd_en interleaved with idle cycles in READOUT → no valid_out in IDLE. In READOUT, valid_out occurs exactly 1 cycle after each rd_en, with addresses strictly sequential.

Source files
------------

// File: rtl/conv_frame_sink.sv
// Frame sink for a conv-stage raster stream: captures D*D pixels into an on-chip
// buffer, tracks row/column of the next pixel, then replays the frame on rd_en.
module conv_frame_sink #(
  parameter int D          = 299,
  parameter int data_width = 32,
  parameter int addr_width = 17
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  valid_in,
  input  logic [data_width-1:0] pxl_in,
  input  logic                  rd_en,
  output logic [data_width-1:0] pxl_out,
  output logic                  valid_out,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  overrun,
  output logic [addr_width-1:0] row,
  output logic [addr_width-1:0] col
);

  localparam int T      = D * D;
  localparam int MEM_AW = (T > 1) ? $clog2(T) : 1;

  localparam logic [addr_width-1:0] LAST_PIX = addr_width'(T - 1);
  localparam logic [addr_width-1:0] LAST_COL = addr_width'(D - 1);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_CAPTURE = 2'd1;
  localparam logic [1:0] S_DONE    = 2'd2;
  localparam logic [1:0] S_READOUT = 2'd3;

  logic [data_width-1:0] frame_mem [0:T-1];

  logic [1:0]            state_q, state_d;
  logic [addr_width-1:0] wr_cnt_q, wr_cnt_d;
  logic [addr_width-1:0] rd_cnt_q, rd_cnt_d;
  logic [addr_width-1:0] row_q, row_d;
  logic [addr_width-1:0] col_q, col_d;
  logic                  overrun_q, overrun_d;
  logic [data_width-1:0] pxl_out_q;
  logic                  valid_out_q;

  logic wr_fire;
  logic rd_fire;

  assign wr_fire = (state_q == S_CAPTURE) && valid_in;
  assign rd_fire = rd_en && ((state_q == S_DONE) || (state_q == S_READOUT));

  always_comb begin
    state_d   = state_q;
    wr_cnt_d  = wr_cnt_q;
    rd_cnt_d  = rd_cnt_q;
    row_d     = row_q;
    col_d     = col_q;
    overrun_d = overrun_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_CAPTURE;
          wr_cnt_d  = '0;
          row_d     = '0;
          col_d     = '0;
          overrun_d = 1'b0;
        end
      end
      S_CAPTURE: begin
        if (valid_in) begin
          if (wr_cnt_q == LAST_PIX) begin
            state_d  = S_DONE;
            wr_cnt_d = '0;
            rd_cnt_d = '0;
            row_d    = '0;
            col_d    = '0;
          end else begin
            wr_cnt_d = wr_cnt_q + 1'b1;
            if (col_q == LAST_COL) begin
              col_d = '0;
              row_d = row_q + 1'b1;
            end else begin
              col_d = col_q + 1'b1;
            end
          end
        end
      end
      S_DONE, S_READOUT: begin
        // The frame is held read-only until drained; late pixels only flag overrun.
        if (valid_in) overrun_d = 1'b1;
        if (rd_en) begin
          if (rd_cnt_q == LAST_PIX) begin
            state_d  = S_IDLE;
            rd_cnt_d = '0;
          end else begin
            state_d  = S_READOUT;
            rd_cnt_d = rd_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      wr_cnt_q  <= '0;
      rd_cnt_q  <= '0;
      row_q     <= '0;
      col_q     <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_cnt_q  <= wr_cnt_d;
      rd_cnt_q  <= rd_cnt_d;
      row_q     <= row_d;
      col_q     <= col_d;
      overrun_q <= overrun_d;
    end
  end

  // Buffer contents survive reset; only the control path is cleared.
  always_ff @(posedge clk) begin
    if (wr_fire) frame_mem[wr_cnt_q[MEM_AW-1:0]] <= pxl_in;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pxl_out_q   <= '0;
      valid_out_q <= 1'b0;
    end else begin
      valid_out_q <= rd_fire;
      if (rd_fire) pxl_out_q <= frame_mem[rd_cnt_q[MEM_AW-1:0]];
    end
  end

  assign pxl_out    = pxl_out_q;
  assign valid_out  = valid_out_q;
  assign busy       = (state_q == S_CAPTURE);
  assign frame_done = (state_q == S_DONE) || (state_q == S_READOUT);
  assign overrun    = overrun_q;
  assign row        = row_q;
  assign col        = col_q;

endmodule

// File: tb/tb_conv_frame_sink.sv
// Bench for conv_frame_sink at D=4: table-driven capture/readout plus hand-written
// sequences for gaps, start/valid collision, overrun and mid-frame reset.
module tb_conv_frame_sink;

  localparam int D  = 4;
  localparam int T  = D * D;
  localparam int DW = 32;
  localparam int AW = 17;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          valid_in = 1'b0;
  logic [DW-1:0] pxl_in = '0;
  logic          rd_en = 1'b0;
  logic [DW-1:0] pxl_out;
  logic          valid_out;
  logic          busy;
  logic          frame_done;
  logic          overrun;
  logic [AW-1:0] row;
  logic [AW-1:0] col;

  conv_frame_sink #(.D(D), .data_width(DW), .addr_width(AW)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .valid_in  (valid_in),
    .pxl_in    (pxl_in),
    .rd_en     (rd_en),
    .pxl_out   (pxl_out),
    .valid_out (valid_out),
    .busy      (busy),
    .frame_done(frame_done),
    .overrun   (overrun),
    .row       (row),
    .col       (col)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] golden [T];
  logic [DW-1:0] exp_q [$];
  int            rd_idx;

  typedef struct {
    bit            start;
    bit            valid;
    bit            rd;
    bit            rexp;
    logic [DW-1:0] pxl;
    bit            exp_busy;
    bit            exp_done;
    logic [AW-1:0] exp_row;
    logic [AW-1:0] exp_col;
  } vec_t;

  vec_t tbl [2*T+2];

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle; a read that should fire queues its expected word, which is
  // popped and compared when valid_out shows up right after the edge.
  task automatic step(input bit s, input bit v, input bit r, input bit rexp, input logic [DW-1:0] p);
    logic [DW-1:0] e;
    start = s; valid_in = v; rd_en = r; pxl_in = p;
    if (r && rexp) begin
      exp_q.push_back(golden[rd_idx]);
      rd_idx++;
    end
    @(posedge clk); #1;
    start = 1'b0; valid_in = 1'b0; rd_en = 1'b0;
    chk("valid_out", {31'd0, valid_out}, {31'd0, r && rexp});
    if (r && rexp) begin
      e = exp_q.pop_front();
      if (valid_out) begin
        chk("pxl_out", pxl_out, e);
        $display("read addr=%0d data=%h expected=%h", rd_idx - 1, pxl_out, e);
      end
    end
  endtask

  task automatic chk_pos(input string name, input int n);
    chk({name, "_row"}, 32'(row), 32'(n / D));
    chk({name, "_col"}, 32'(col), 32'(n % D));
  endtask

  task automatic capture_frame(input bit gaps);
    for (int k = 0; k < T; k++) begin
      if (gaps) begin
        for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
          step(0, 0, 0, 0, 32'hdead_beef);
          chk_pos("gap_hold", k);
        end
      end
      step(0, 1, 0, 0, golden[k]);
      if (k < T - 1) begin
        chk_pos("cap_pos", k + 1);
        chk("cap_busy", {31'd0, busy}, 32'd1);
      end
    end
    chk("cap_end_busy", {31'd0, busy}, 32'd0);
    chk("cap_end_done", {31'd0, frame_done}, 32'd1);
    chk_pos("cap_end_pos", 0);
  endtask

  task automatic readout(input bit gaps);
    rd_idx = 0;
    for (int k = 0; k < T; k++) begin
      step(0, 0, 1, 1, 32'd0);
      chk("rd_done", {31'd0, frame_done}, {31'd0, k < T - 1});
      if (gaps) begin
        for (int g = 0; g < int'($urandom_range(0, 2)); g++) step(0, 0, 0, 0, 32'd0);
      end
    end
    step(0, 0, 0, 0, 32'd0);
    chk("rd_after_done", {31'd0, frame_done}, 32'd0);
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_pxl"}, pxl_out, 32'd0);
    chk({name, "_flags"}, {27'd0, valid_out, busy, frame_done, overrun, 1'b0}, 32'd0);
    chk({name, "_row"}, 32'(row), 32'd0);
    chk({name, "_col"}, 32'(col), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    #12;
    chk_all_zero("reset");
    @(posedge clk); #1;
    reset = 1'b0;

    // Table: start, 16 writes, 16 back-to-back reads, one idle cycle.
    for (int k = 0; k < T; k++) golden[k] = 32'h3f80_0000 + k;
    tbl[0] = '{1, 0, 0, 0, 32'd0, 1, 0, 0, 0};
    for (int k = 1; k <= T; k++)
      tbl[k] = '{0, 1, 0, 0, golden[k-1], k < T, k == T,
                 AW'((k % T) / D), AW'((k % T) % D)};
    for (int k = 1; k <= T; k++)
      tbl[T+k] = '{0, 0, 1, 1, 32'd0, 0, k < T, 0, 0};
    tbl[2*T+1] = '{0, 0, 0, 0, 32'd0, 0, 0, 0, 0};
    rd_idx = 0;
    for (int i = 0; i < 2*T+2; i++) begin
      step(tbl[i].start, tbl[i].valid, tbl[i].rd, tbl[i].rexp, tbl[i].pxl);
      chk("tbl_busy", {31'd0, busy}, {31'd0, tbl[i].exp_busy});
      chk("tbl_done", {31'd0, frame_done}, {31'd0, tbl[i].exp_done});
      chk("tbl_row", 32'(row), 32'(tbl[i].exp_row));
      chk("tbl_col", 32'(col), 32'(tbl[i].exp_col));
    end

    // rd_en in IDLE is ignored, then capture with gaps and sparse readout.
    step(0, 0, 1, 0, 32'd0);
    step(0, 0, 1, 0, 32'd0);
    for (int k = 0; k < T; k++) golden[k] = $urandom;
    step(1, 0, 0, 0, 32'd0);
    chk("gap_start_busy", {31'd0, busy}, 32'd1);
    step(0, 0, 1, 0, 32'd0);
    capture_frame(1);
    readout(1);

    // start together with valid_in: that pixel must not be stored.
    step(1, 1, 0, 0, 32'hbad0_0001);
    chk("coll_busy", {31'd0, busy}, 32'd1);
    chk_pos("coll_pos", 0);
    for (int k = 0; k < T; k++) golden[k] = 32'h4000_0000 + 32'(k * 3);
    capture_frame(0);

    // Late pixels in DONE/READOUT set a sticky overrun without touching the frame.
    step(0, 1, 0, 0, 32'hbad0_0002);
    chk("ovr_set", {31'd0, overrun}, 32'd1);
    step(0, 0, 0, 0, 32'd0);
    chk("ovr_hold", {31'd0, overrun}, 32'd1);
    rd_idx = 0;
    for (int k = 0; k < T; k++) step(0, k == 5, 1, 1, 32'hbad0_0003);
    chk("ovr_after_rd", {31'd0, overrun}, 32'd1);
    step(1, 0, 0, 0, 32'd0);
    chk("ovr_cleared", {31'd0, overrun}, 32'd0);

    // Reset after 7 pixels, then a fresh full frame.
    for (int k = 0; k < 7; k++) step(0, 1, 0, 0, 32'h1111_0000 + k);
    chk_pos("pre_reset", 7);
    #2 reset = 1'b1;
    #1;
    chk_all_zero("mid_reset");
    @(posedge clk); #1;
    reset = 1'b0;
    step(0, 1, 0, 0, 32'hbad0_0004);
    chk("idle_valid_busy", {31'd0, busy}, 32'd0);
    chk("idle_valid_ovr", {31'd0, overrun}, 32'd0);
    for (int k = 0; k < T; k++) golden[k] = 32'hc000_0000 ^ $urandom;
    step(1, 0, 0, 0, 32'd0);
    capture_frame(0);
    readout(0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
